// File: rtl/instr_encoder_pkg.sv
// rtl/instr_encoder_pkg.sv - shared opcodes, class codes, NOP word and FSM state type
package instr_encoder_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] CLS_R      = 3'd0;
    localparam logic [2:0] CLS_I      = 3'd1;
    localparam logic [2:0] CLS_LW     = 3'd2;
    localparam logic [2:0] CLS_SW     = 3'd3;
    localparam logic [2:0] CLS_BRANCH = 3'd4;

    localparam logic [2:0] F3_WORD    = 3'b010;

    // addi x0,x0,0
    localparam logic [31:0] NOP_WORD  = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FULL  = 2'd2
    } enc_state_e;

endpackage

// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - request handshake and instruction-memory write bus
interface instr_encoder_if #(
    parameter int ADDR_W = 8
) ();
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_class;
    logic [2:0]        req_funct3;
    logic              req_funct7b5;
    logic [4:0]        req_rd;
    logic [4:0]        req_rs1;
    logic [4:0]        req_rs2;
    logic [11:0]       req_imm;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              imem_ready;

    modport slave (
        input  req_valid, req_class, req_funct3, req_funct7b5,
        input  req_rd, req_rs1, req_rs2, req_imm, imem_ready,
        output req_ready, imem_we, imem_addr, imem_wdata
    );

    modport master (
        output req_valid, req_class, req_funct3, req_funct7b5,
        output req_rd, req_rs1, req_rs2, req_imm, imem_ready,
        input  req_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/instr_field_packer.sv
// rtl/instr_field_packer.sv - combinational class+fields to RV32 word, plus legal flag
module instr_field_packer
    import instr_encoder_pkg::*;
(
    input  logic [2:0]  cls_i,
    input  logic [2:0]  funct3_i,
    input  logic        funct7b5_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [11:0] imm_i,
    output logic [31:0] word_o,
    output logic        legal_o
);

    always_comb begin
        word_o  = 32'h0;
        legal_o = 1'b1;
        case (cls_i)
            CLS_R:      word_o = {1'b0, funct7b5_i, 5'b00000, rs2_i, rs1_i, funct3_i, rd_i, OPC_R};
            CLS_I:      word_o = {imm_i, rs1_i, funct3_i, rd_i, OPC_I};
            CLS_LW:     word_o = {imm_i, rs1_i, F3_WORD, rd_i, OPC_LOAD};
            CLS_SW:     word_o = {imm_i[11:5], rs2_i, rs1_i, F3_WORD, imm_i[4:0], OPC_STORE};
            // imm_i holds byte-offset bits [12:1], so index n here is offset bit n+1
            CLS_BRANCH: word_o = {imm_i[11], imm_i[9:4], rs2_i, rs1_i, funct3_i,
                                  imm_i[3:0], imm_i[10], OPC_BRANCH};
            default:    legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - encode requests and stream words into instruction memory (INSTR_ENCODER_NOP_FILL_EN: NOP for illegal class)
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    instr_encoder_if.slave  bus,
    output logic            full,
    output logic            err
);

    enc_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              full_q, full_d;
    logic              err_q, err_d;

    logic [31:0]       packed_word;
    logic              packed_legal;

    instr_field_packer u_packer (
        .cls_i      (bus.req_class),
        .funct3_i   (bus.req_funct3),
        .funct7b5_i (bus.req_funct7b5),
        .rd_i       (bus.req_rd),
        .rs1_i      (bus.req_rs1),
        .rs2_i      (bus.req_rs2),
        .imm_i      (bus.req_imm),
        .word_o     (packed_word),
        .legal_o    (packed_legal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            full_q  <= full_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        full_d  = full_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    if (!packed_legal) err_d = 1'b1;
`ifdef INSTR_ENCODER_NOP_FILL_EN
                    wdata_d = packed_legal ? packed_word : NOP_WORD;
                    state_d = ST_WRITE;
`else
                    if (packed_legal) begin
                        wdata_d = packed_word;
                        state_d = ST_WRITE;
                    end
`endif
                end
            end
            ST_WRITE: begin
                if (bus.imem_ready) begin
                    // The last slot is kept rather than wrapped so earlier code is never overwritten
                    if (addr_q == {ADDR_W{1'b1}}) begin
                        full_d  = 1'b1;
                        state_d = ST_FULL;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_FULL:  state_d = ST_FULL;
            default:  state_d = ST_IDLE;
        endcase
        if (clear) begin
            state_d = ST_IDLE;
            addr_d  = '0;
            full_d  = 1'b0;
            err_d   = 1'b0;
        end
    end

    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.imem_we    = (state_q == ST_WRITE);
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign full           = full_q;
    assign err            = err_q;

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, instruction-memory word-address width.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port clear  input  1  synchronous: address to 0, full and err to 0, state to IDLE.
REQ-005 SHALL have port req_valid  input  1  encode request present.
REQ-006 SHALL have port req_ready  output  1  request accepted on the edge where req_valid&req_ready is high.
REQ-007 SHALL have port req_class  input  3  0=R, 1=I-ALU, 2=LW, 3=SW, 4=BRANCH; 5-7 illegal.
REQ-008 SHALL have ports req_funct3 (input 3) and req_funct7b5 (input 1, instruction bit 30).
REQ-009 SHALL have ports req_rd, req_rs1, req_rs2  input  5 each  register indices.
REQ-010 SHALL have port req_imm  input  12  imm[11:0]; for BRANCH it carries byte-offset bits [12:1].
REQ-011 SHALL have ports imem_we (output 1), imem_addr (output ADDR_W), imem_wdata (output 32).
REQ-012 SHALL have port imem_ready  input  1  memory accepts the write in a cycle where imem_we=1.
REQ-013 SHALL have ports full (output 1, last address written) and err (output 1, sticky illegal-class flag).

Function
REQ-014 SHALL implement FSM IDLE -> WRITE -> (IDLE | FULL); req_ready=1 only in IDLE with full=0.
REQ-015 SHALL register the encoded 32-bit word on acceptance; imem_we=1 from the next cycle, latency exactly 1.
REQ-016 SHALL hold imem_we, imem_addr and imem_wdata stable in WRITE until imem_ready=1.
REQ-017 SHALL increment imem_addr by 1 on each completed write, and return to IDLE unless the address was 2^ADDR_W-1.
REQ-018 SHALL on completing the write at the last address set full=1, enter FULL, keep the address (no wrap), and hold req_ready=0 until clear or rst.
REQ-019 SHALL encode R as {0,funct7b5,00000,rs2,rs1,funct3,rd,0110011}.
REQ-020 SHALL encode I as {imm,rs1,funct3,rd,0010011}.
REQ-021 SHALL encode LW as {imm,rs1,010,rd,0000011}, ignoring funct3.
REQ-022 SHALL encode SW as {imm[11:5],rs2,rs1,010,imm[4:0],0100011}.
REQ-023 SHALL encode BRANCH as {req_imm[11],req_imm[9:4],rs2,rs1,funct3,req_imm[3:0],req_imm[10],1100011}.
REQ-024 SHALL on an accepted illegal class set err=1, with the write behaviour given by REQ-028/029.
REQ-025 SHALL give clear priority over a concurrent acceptance or write completion; any in-flight write is abandoned.

Reset
REQ-026 SHALL on rst, regardless of clock or state: state=IDLE, imem_addr=0, imem_wdata=0, imem_we=0, full=0, err=0, req_ready=1 once rst deasserts.
REQ-027 SHALL discard a write pending in WRITE when rst asserts mid-operation; nothing is replayed.

Configuration
REQ-028 SHALL, with macro INSTR_ENCODER_NOP_FILL_EN defined, write 32'h00000013 (addi x0,x0,0) for an illegal class, keeping the program image contiguous.
REQ-029 SHALL, without INSTR_ENCODER_NOP_FILL_EN, drop an illegal request: no write, address unchanged, stay in IDLE.

Structure
REQ-030 SHALL place in shared package instr_encoder_pkg: the opcode constants (0110011, 0010011, 0000011, 0100011, 1100011), the class codes, the NOP constant and the FSM state type.
REQ-031 SHALL use one combinational sub-module, instr_field_packer (class+fields -> 32-bit word plus legal flag), leaving the FSM and counters in instr_encoder.

Verification
REQ-032 SHALL test R/I: add x3,x1,x2 (class0,f3=0,b5=0) -> 0x002081B3 at addr 0; sub x5,x6,x7 (b5=1) -> 0x407302B3 at addr 1.
REQ-033 SHALL test memory ops: lw x4,8(x0) -> 0x00802203; sw x5,12(x2) -> 0x00512623.
REQ-034 SHALL test BRANCH: beq x1,x2,-8 (req_imm=12'hFFC, f3=0) -> 0xFE208CE3.
REQ-035 SHALL test backpressure: imem_ready low for 3 cycles -> imem_we/addr/wdata stable, req_ready=0, a single write on release.
REQ-036 SHALL test full: ADDR_W=2, 4 writes -> full=1, 5th request stalls with req_ready=0; clear -> addr=0, req_ready=1.
REQ-037 SHALL test errors and reset: class 6 -> err=1 and a NOP write (macro) or no write (no macro); rst asserted mid-WRITE -> imem_we=0 immediately, addr=0.
